regfile_dump_reader: RTL and testbench

//  Reader-side companion to the 32x32 register file. On start it walks the read port (Ra/busA)

---
 rtl/rf_dump_pkg.sv | 23 ++
 rtl/regfile_dump_reader.sv | 141 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_dump_pkg
//  Description : Shared constants for the register-file dump reader: state
//                encoding and default register-file geometry, also used by
//                the CPU top.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_dump_pkg;

    // Default register-file geometry
    localparam int c_NUM_REGS = 32;
    localparam int c_ADDR_W   = 5;
    localparam int c_DATA_W   = 32;

    // Dump-reader state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_OUT   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

endpackage : rf_dump_pkg
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_reader
//  Description : Walks register-file read port A from FIRST_REG up to
//                NUM_REGS-1 and streams every value over a valid/ready
//                channel, keeping an XOR checksum of the accepted values.
//                One value per two cycles at most (FETCH then OUT).
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS  = c_NUM_REGS,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int FIRST_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] Ra,
    input  logic [DATA_W-1:0] busA,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_index,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] c_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] c_ONE   = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_ra;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_checksum;
    logic              w_last;

    // The terminal compare stops the walk before idx can wrap
    assign w_last = (r_idx == c_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort outranks a simultaneous handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                w_next_state = abort ? c_ST_IDLE : c_ST_OUT;
            end
            c_ST_OUT: begin
                if (abort) begin
                    w_next_state = c_ST_IDLE;
                end else if (dout_ready) begin
                    w_next_state = w_last ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Datapath: address walk, output capture/hold and checksum accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_ra       <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_index    <= '0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_idx      <= c_FIRST;
                        r_ra       <= c_FIRST;
                        r_checksum <= '0;
                    end
                end
                c_ST_FETCH: begin
                    // busA already reflects Ra; sample it on this edge
                    if (!abort) begin
                        r_data  <= busA;
                        r_index <= r_idx;
                        r_valid <= 1'b1;
                    end
                end
                c_ST_OUT: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                    end else if (dout_ready) begin
                        r_valid    <= 1'b0;
                        r_checksum <= r_checksum ^ r_data;
                        if (!w_last) begin
                            r_idx <= r_idx + c_ONE;
                            r_ra  <= r_idx + c_ONE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Ra         = r_ra;
    assign dout_valid = r_valid;
    assign dout_data  = r_data;
    assign dout_index = r_index;
    assign checksum   = r_checksum;
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);

endmodule : regfile_dump_reader
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_dump_reader
//  Description : Directed self-checking bench for regfile_dump_reader with a
//                behavioural register file (R1=4, R2=5, R31=FFFF0000).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dout_ready = 1'b1;
    logic [4:0]  Ra;
    logic [31:0] busA;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic [4:0]  dout_index;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic        start31 = 1'b0;
    logic        abort31 = 1'b0;
    logic        ready31 = 1'b1;
    logic [4:0]  Ra31;
    logic [31:0] busA31;
    logic        valid31;
    logic [31:0] data31;
    logic [4:0]  index31;
    logic        busy31;
    logic        done31;
    logic [31:0] checksum31;

    logic [31:0] regs [32];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_cnt31 = 0;
    int beats31 = 0;
    logic [4:0]  last_idx31 = '0;
    logic [31:0] last_dat31 = '0;
    logic [4:0]  q_idx [$];
    logic [31:0] q_dat [$];

    always #5 clk = ~clk;

    assign busA   = regs[Ra];
    assign busA31 = regs[Ra31];

    regfile_dump_reader #(
        .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .Ra(Ra), .busA(busA),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_index(dout_index), .busy(busy), .done(done), .checksum(checksum)
    );

    regfile_dump_reader #(
        .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(31)
    ) dut31 (
        .clk(clk), .rst(rst), .start(start31), .abort(abort31), .Ra(Ra31), .busA(busA31),
        .dout_valid(valid31), .dout_ready(ready31), .dout_data(data31),
        .dout_index(index31), .busy(busy31), .done(done31), .checksum(checksum31)
    );

    // Record accepted beats and done pulses of the main instance
    always @(posedge clk) begin
        if (!rst && dout_valid && dout_ready && !abort) begin
            q_idx.push_back(dout_index);
            q_dat.push_back(dout_data);
        end
        if (!rst && done) done_cnt++;
    end

    // Record accepted beats and done pulses of the FIRST_REG=31 instance
    always @(posedge clk) begin
        if (!rst && valid31 && ready31 && !abort31) begin
            beats31++;
            last_idx31 = index31;
            last_dat31 = data31;
        end
        if (!rst && done31) done_cnt31++;
    end

    function automatic logic [31:0] exp_reg(input int i);
        case (i)
            1:       return 32'd4;
            2:       return 32'd5;
            31:      return 32'hFFFF0000;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a dump and service it until done; optional stall and re-start injection
    task automatic run_dump(input int stall_idx, input int restart_idx,
                            output int stalls, output int hold_err, output bit timeout);
        int  d0;
        bit  restarted;
        stalls = 0; hold_err = 0; timeout = 1; restarted = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        d0 = done_cnt;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                timeout = 0;
                break;
            end
            dout_ready = 1'b1;
            start = 1'b0;
            if (dout_valid && int'(dout_index) == stall_idx && stalls < 5) begin
                dout_ready = 1'b0;
                stalls++;
                if (dout_data !== exp_reg(stall_idx)) hold_err++;
            end
            if (dout_valid && int'(dout_index) == restart_idx && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
        end
        dout_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic check_full(input string tag, input int d0);
        int err;
        err = 0;
        repeat (3) @(negedge clk);
        check({tag, "_beats"}, q_idx.size(), 32);
        for (int i = 0; i < q_idx.size(); i++) begin
            if (int'(q_idx[i]) != i || q_dat[i] !== exp_reg(i)) err++;
        end
        check({tag, "_order_data"}, err, 0);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_checksum"}, checksum, 32'hFFFF0001);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int  stalls, hold_err, d0;
        bit  timeout;

        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1]  = 32'd4;
        regs[2]  = 32'd5;
        regs[31] = 32'hFFFF0000;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_ra", Ra, 0);
        check("rst_data", dout_data, 0);
        check("rst_index", dout_index, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: latency then full dump with ready tied high
        q_idx.delete(); q_dat.delete();
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("s1_fetch_busy", busy, 1);
        check("s1_fetch_valid", dout_valid, 0);
        @(negedge clk);
        check("s1_out_valid", dout_valid, 1);
        check("s1_out_index", dout_index, 0);
        timeout = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done_cnt != d0) begin timeout = 0; break; end
        end
        check("s1_timeout", timeout, 0);
        check_full("s1", d0);

        // 2: backpressure on index 2 for 5 cycles
        q_idx.delete(); q_dat.delete();
        d0 = done_cnt;
        run_dump(2, -1, stalls, hold_err, timeout);
        check("s2_timeout", timeout, 0);
        check("s2_stall_cycles", stalls, 5);
        check("s2_hold_data", hold_err, 0);
        check_full("s2", d0);

        // 3: abort together with the handshake on index 1
        q_idx.delete(); q_dat.delete();
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        timeout = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dout_valid && dout_index == 5'd1) begin timeout = 0; break; end
        end
        check("s3_timeout", timeout, 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("s3_busy", busy, 0);
        check("s3_valid", dout_valid, 0);
        check("s3_checksum", checksum, 0);
        repeat (3) @(negedge clk);
        check("s3_no_done", done_cnt - d0, 0);
        check("s3_still_idle", busy, 0);

        // 4: start re-pulsed mid-dump is ignored
        q_idx.delete(); q_dat.delete();
        d0 = done_cnt;
        run_dump(-1, 5, stalls, hold_err, timeout);
        check("s4_timeout", timeout, 0);
        check_full("s4", d0);

        // 5: async reset in the middle of OUT, then a clean dump
        q_idx.delete(); q_dat.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        timeout = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (dout_valid && dout_index == 5'd3) begin timeout = 0; break; end
        end
        check("s5_timeout", timeout, 0);
        check("s5_pre_checksum", checksum, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("s5_rst_valid", dout_valid, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_checksum", checksum, 0);
        @(negedge clk); rst = 1'b0;
        q_idx.delete(); q_dat.delete();
        d0 = done_cnt;
        run_dump(-1, -1, stalls, hold_err, timeout);
        check("s5_rerun_timeout", timeout, 0);
        check_full("s5", d0);

        // 6: FIRST_REG=31 instance streams exactly one beat
        @(negedge clk); start31 = 1'b1;
        @(negedge clk); start31 = 1'b0;
        timeout = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done_cnt31 != 0) begin timeout = 0; break; end
        end
        repeat (3) @(negedge clk);
        check("s6_timeout", timeout, 0);
        check("s6_beats", beats31, 1);
        check("s6_index", last_idx31, 5'd31);
        check("s6_data", last_dat31, 32'hFFFF0000);
        check("s6_done_once", done_cnt31, 1);
        check("s6_checksum", checksum31, 32'hFFFF0000);
        check("s6_idle", busy31, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_dump_reader
`default_nettype wire
